// File: rtl/color_freq_pkg.sv
// Shared types and constants for the colour sensor frequency meter.
package color_freq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GATE   = 2'd2,
        S_STORE  = 2'd3
    } state_t;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_CNT_W         = 20;
    localparam int DEF_GATE_CYCLES   = 100_000;
    localparam int DEF_SETTLE_CYCLES = 10_000;
    localparam int DEF_AVG_LOG2      = 2;

    // Channel index width; a single channel still needs a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/color_freq_meter_pulse_edge_sync.sv
// Two-flop synchronizer for the asynchronous sensor pulse train followed by
// a rising-edge detector producing a one-cycle pulse.
module pulse_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    // Synchronizer chain plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= din;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync_prev;

endmodule

// File: rtl/color_freq_meter.sv
// Multi-channel frequency meter for the colour sensor: steps the filter
// select, settles, counts sensor edges over averaged gate windows and
// publishes a per-channel count frame with the dominant colour channel.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for enable; outputs hold the last published frame
// SETTLE | filter just changed; edges are ignored for SETTLE_CYCLES
// GATE   | counting edges; repeats 2^AVG_LOG2 windows per channel
// STORE  | one cycle: write channel average, advance or publish frame
module color_freq_meter
    import color_freq_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2,
    localparam int CH_W         = ch_w(NUM_CH)
) (
    input  logic             CLK100MHZ,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             signal,
    output logic [CH_W-1:0]  filter_sel,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_count,
    output logic             frame_valid,
    output logic [CH_W-1:0]  dominant,
    output logic             overflow,
    output logic             busy
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int ACC_W   = CNT_W + AVG_LOG2;
    localparam int AVG_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [AVG_W-1:0] AVG_LAST    = AVG_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] win_next;
    logic [ACC_W-1:0] acc;
    logic [AVG_W-1:0] avg_idx;
    logic             frame_ovf;
    logic             sat_hit;
    logic             edge_pulse;
    logic [CNT_W-1:0] store_val;
    logic [CH_W-1:0]  dom_idx;
    logic [CNT_W-1:0] dom_val;

    logic [CNT_W-1:0] shadow   [NUM_CH];
    logic [CNT_W-1:0] out_regs [NUM_CH];

    pulse_edge_sync u_sync (
        .clk        (CLK100MHZ),
        .rst_n      (rst_n),
        .din        (signal),
        .edge_pulse (edge_pulse)
    );

    // Window counter sticks at all-ones; an edge arriving there is lost.
    assign sat_hit   = edge_pulse & (&win_cnt);
    assign win_next  = (edge_pulse && !(&win_cnt)) ? win_cnt + 1'b1 : win_cnt;
    assign store_val = CNT_W'(acc >> AVG_LOG2);
    assign busy      = (state != S_IDLE);

    // Dominant channel over the filtered channels; strict compare keeps ties on the lowest index.
    always_comb begin
        dom_idx = '0;
        dom_val = shadow[0];
        for (int i = 1; i < NUM_CH - 1; i++) begin
            if (shadow[i] > dom_val) begin
                dom_val = shadow[i];
                dom_idx = CH_W'(i);
            end
        end
    end

    // Read port into the published frame only; out-of-range channels read 0.
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_count = out_regs[i];
        end
    end

    // Sequencer: settle, gated counting with averaging, store and publish.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            filter_sel  <= '0;
            timer       <= '0;
            win_cnt     <= '0;
            acc         <= '0;
            avg_idx     <= '0;
            frame_ovf   <= 1'b0;
            frame_valid <= 1'b0;
            dominant    <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i]   <= '0;
                out_regs[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state      <= S_SETTLE;
                        filter_sel <= '0;
                        timer      <= SETTLE_LOAD;
                        win_cnt    <= '0;
                        acc        <= '0;
                        avg_idx    <= '0;
                        frame_ovf  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (timer == '0) begin
                        state   <= S_GATE;
                        timer   <= GATE_LOAD;
                        win_cnt <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_GATE: begin
                    if (sat_hit) frame_ovf <= 1'b1;
                    if (timer == '0) begin
                        // The edge seen in the final gate cycle still belongs to this window.
                        acc     <= acc + ACC_W'(win_next);
                        win_cnt <= '0;
                        if (avg_idx == AVG_LAST) begin
                            state <= S_STORE;
                        end else begin
                            avg_idx <= avg_idx + 1'b1;
                            timer   <= GATE_LOAD;
                        end
                    end else begin
                        win_cnt <= win_next;
                        timer   <= timer - 1'b1;
                    end
                end
                S_STORE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (filter_sel == CH_W'(i)) shadow[i] <= store_val;
                    end
                    acc     <= '0;
                    avg_idx <= '0;
                    timer   <= SETTLE_LOAD;
                    if (filter_sel != LAST_CH) begin
                        filter_sel <= filter_sel + 1'b1;
                        state      <= S_SETTLE;
                    end else begin
                        // Last channel's value is not in shadow yet, so publish it directly.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (i == NUM_CH - 1) out_regs[i] <= store_val;
                            else                 out_regs[i] <= shadow[i];
                        end
                        dominant    <= (NUM_CH > 1) ? dom_idx : '0;
                        overflow    <= frame_ovf;
                        frame_valid <= 1'b1;
                        frame_ovf   <= 1'b0;
                        filter_sel  <= '0;
                        state       <= enable ? S_SETTLE : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_freq_meter.sv
// Scoreboard bench for color_freq_meter: stimulus pushes expected frames,
// monitors pop and compare whenever frame_valid is presented.
module tb_color_freq_meter;

    localparam int CH      = 4;
    localparam int SPAN    = 100 + 2 * 1000 + 1;
    localparam int FRAME   = CH * SPAN;
    localparam int M_OFF   = 0;
    localparam int M_SQ100 = 1;
    localparam int M_DOM   = 2;
    localparam int M_SET   = 3;

    typedef struct packed {
        logic [3:0][31:0] cnt;
        logic [31:0]      dom;
        logic             ovf;
        logic             chk_cyc;
        logic [31:0]      cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, enable, sig, enable_sat, sig_sat;
    logic [1:0]  filter_sel, rd_ch, dominant;
    logic [1:0]  filter_sel_sat, rd_ch_sat, dominant_sat;
    logic [19:0] rd_count;
    logic [3:0]  rd_count_sat;
    logic        frame_valid, overflow, busy;
    logic        frame_valid_sat, overflow_sat, busy_sat;

    color_freq_meter #(.NUM_CH(4), .CNT_W(20), .GATE_CYCLES(1000), .SETTLE_CYCLES(100), .AVG_LOG2(1)) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .enable(enable), .signal(sig),
        .filter_sel(filter_sel), .rd_ch(rd_ch), .rd_count(rd_count),
        .frame_valid(frame_valid), .dominant(dominant), .overflow(overflow), .busy(busy)
    );

    color_freq_meter #(.NUM_CH(4), .CNT_W(4), .GATE_CYCLES(1000), .SETTLE_CYCLES(100), .AVG_LOG2(1)) dut_sat (
        .CLK100MHZ(clk), .rst_n(rst_n), .enable(enable_sat), .signal(sig_sat),
        .filter_sel(filter_sel_sat), .rd_ch(rd_ch_sat), .rd_count(rd_count_sat),
        .frame_valid(frame_valid_sat), .dominant(dominant_sat), .overflow(overflow_sat), .busy(busy_sat)
    );

    int   total = 0;
    int   bad = 0;
    int   mode = M_OFF;
    int   fstart = 0;
    int   zero_req = 0;
    int   zero_done = 0;
    int   frames_seen = 0;
    int   frames_sat = 0;
    exp_t exp_q[$];
    exp_t sat_q[$];

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input int c0, input int c1, input int c2, input int c3,
                                input int d, input bit o, input bit tc, input int cy);
        exp_t e;
        e.cnt[0] = c0; e.cnt[1] = c1; e.cnt[2] = c2; e.cnt[3] = c3;
        e.dom = d; e.ovf = o; e.chk_cyc = tc; e.cyc = cy;
        return e;
    endfunction

    // Sensor model: pattern chosen by mode, dominant mode keyed on filter select.
    initial begin
        int per;
        int p;
        sig = 1'b0;
        sig_sat = 1'b0;
        forever begin
            @(negedge clk);
            sig_sat = (cyc % 4) < 2;
            case (mode)
                M_SQ100: sig = (cyc % 100) < 50;
                M_DOM: begin
                    case (filter_sel)
                        2'd0: per = 200;
                        2'd1: per = 50;
                        2'd2: per = 100;
                        default: per = 20;
                    endcase
                    sig = (cyc % per) < (per / 2);
                end
                M_SET: begin
                    p = (cyc - fstart) % SPAN;
                    sig = (p < 60) && ((p % 10) < 5);
                end
                default: sig = 1'b0;
            endcase
        end
    end

    // Monitor for the main instance.
    initial begin
        exp_t e;
        rd_ch = '0;
        forever begin
            @(negedge clk);
            if (frame_valid) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_cyc) check("frame_time", cyc, e.cyc);
                    check("dominant", dominant, e.dom);
                    check("overflow", overflow, e.ovf);
                    for (int i = 0; i < CH; i++) begin
                        rd_ch = 2'(i);
                        #1;
                        check("rd_count", rd_count, e.cnt[i]);
                    end
                end
            end
            if (zero_req != zero_done) begin
                for (int i = 0; i < CH; i++) begin
                    rd_ch = 2'(i);
                    #1;
                    check("rd_count_after_reset", rd_count, 0);
                end
                zero_done++;
            end
        end
    end

    // Monitor for the narrow-counter instance.
    initial begin
        exp_t e;
        rd_ch_sat = '0;
        forever begin
            @(negedge clk);
            if (frame_valid_sat) begin
                frames_sat++;
                if (sat_q.size() == 0) begin
                    check("sat_unexpected_frame_valid", 1, 0);
                end else begin
                    e = sat_q.pop_front();
                    if (e.chk_cyc) check("sat_frame_time", cyc, e.cyc);
                    check("sat_dominant", dominant_sat, e.dom);
                    check("sat_overflow", overflow_sat, e.ovf);
                    for (int i = 0; i < CH; i++) begin
                        rd_ch_sat = 2'(i);
                        #1;
                        check("sat_rd_count", rd_count_sat, e.cnt[i]);
                    end
                end
            end
        end
    end

    task automatic wait_fv(input int limit, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_valid && n < limit);
        if (!frame_valid) check(nm, 0, 1);
    endtask

    // Directed stimulus.
    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        enable_sat = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_filter_sel", filter_sel, 0);
        check("reset_frame_valid", frame_valid, 0);
        check("reset_dominant", dominant, 0);
        check("reset_overflow", overflow, 0);
        check("reset_rd_count", rd_count, 0);
        check("reset_sat_busy", busy_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic count with timing, plus saturation on the narrow instance.
        mode = M_SQ100;
        exp_q.push_back(mk(10, 10, 10, 10, 0, 1'b0, 1'b1, cyc + 1 + FRAME));
        sat_q.push_back(mk(15, 15, 15, 15, 0, 1'b1, 1'b1, cyc + 1 + FRAME));
        enable = 1'b1;
        enable_sat = 1'b1;
        @(negedge clk);
        enable_sat = 1'b0;
        check("busy_running", busy, 1);
        wait_fv(FRAME + 50, "frame1_timeout");

        // Dominant select: clear channel has the most edges but is excluded.
        mode = M_DOM;
        exp_q.push_back(mk(5, 20, 10, 50, 1, 1'b0, 1'b0, 0));
        wait_fv(FRAME + 50, "frame2_timeout");

        // Pulses only inside the settle windows.
        mode = M_SET;
        fstart = cyc;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 0));
        wait_fv(FRAME + 50, "frame3_timeout");

        // Enable dropped during channel 1: frame still completes.
        mode = M_SQ100;
        exp_q.push_back(mk(10, 10, 10, 10, 0, 1'b0, 1'b0, 0));
        repeat (3000) @(negedge clk);
        enable = 1'b0;
        check("drop_filter_sel", filter_sel, 1);
        check("drop_busy", busy, 1);
        wait_fv(FRAME + 50, "frame4_timeout");
        check("idle_busy_at_publish", busy, 0);
        repeat (200) @(negedge clk);
        check("idle_busy", busy, 0);

        // Reset during the gate of channel 2.
        enable = 1'b1;
        repeat (5000) @(negedge clk);
        check("pre_reset_filter_sel", filter_sel, 2);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_filter_sel", filter_sel, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_dominant", dominant, 0);
        check("rst_overflow", overflow, 0);
        zero_req++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 200) @(negedge clk);

        check("final_busy", busy, 0);
        check("pending_frames", exp_q.size(), 0);
        check("pending_sat_frames", sat_q.size(), 0);
        check("frames_seen", frames_seen, 4);
        check("sat_frames_seen", frames_sat, 1);
        check("zero_checks_done", zero_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_freq_meter.md
# color_freq_meter

Multi-channel successor to the single-channel frequency front end for the colour sensor. It steps the sensor's filter select through `NUM_CH` channels and waits a settle time after each change. It then counts rising edges of the sensor's `signal` output over a fixed gate window and averages 2^`AVG_LOG2` windows per channel. It publishes a per-channel count frame plus the dominant colour channel, and sits between the sensor pins and the sort/search control logic.

## Interface
- `NUM_CH`, 4: number of filter channels. Channel `NUM_CH-1` is the clear (unfiltered) channel.
- `CNT_W`, 20: width of stored per-channel counts.
- `GATE_CYCLES`, 100_000: clock cycles per gate window (1 ms at 100 MHz).
- `SETTLE_CYCLES`, 10_000: cycles ignored after each filter change.
- `AVG_LOG2`, 2: log2 of windows averaged per channel; 0 disables averaging.
- `CLK100MHZ` in 1: the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: run frames continuously while high.
- `signal` in 1: asynchronous sensor pulse train.
- `filter_sel` out `CH_W`: sensor filter select. Reset value 0.
- `rd_ch` in `CH_W`: channel index for the combinational read port.
- `rd_count` out `CNT_W`: latest frame's count for `rd_ch`. Reset value 0.
- `frame_valid` out 1: one-cycle pulse when a new frame is published. Reset value 0.
- `dominant` out `CH_W`: index of the largest count among channels 0..`NUM_CH-2`. Reset value 0.
- `overflow` out 1: at least one window saturated in the latest frame. Reset value 0.
- `busy` out 1: high whenever the FSM is not in IDLE. Reset value 0.

## Operation
- `signal` passes through a 2-flop synchronizer and then a rising-edge detector. An edge counts one cycle after it is detected.
- FSM has four states: IDLE, SETTLE, GATE, STORE.
  - IDLE → SETTLE when `enable`=1. Sets `filter_sel`=0 and clears the window counter, the accumulator, the average index and the frame overflow flag.
  - SETTLE → GATE after exactly `SETTLE_CYCLES` cycles. Edges during SETTLE are discarded.
  - GATE lasts exactly `GATE_CYCLES` cycles and counts detected edges.
    - The window counter saturates at 2^`CNT_W`-1; saturation sets the frame overflow flag.
    - At window end the window count is added to an accumulator (`CNT_W+AVG_LOG2` bits).
    - If fewer than 2^`AVG_LOG2` windows have run, GATE repeats immediately with no resettle.
  - STORE takes one cycle and writes accumulator >> `AVG_LOG2` into the channel's shadow register.
    - If the channel is not last: `filter_sel`+1 and go to SETTLE.
    - If the channel is last: copy all shadow registers, the dominant index and the overflow flag to the output registers, pulse `frame_valid`, then go to SETTLE with `filter_sel`=0 if `enable`=1, otherwise IDLE.
- Dominant channel: the maximum over channels 0..`NUM_CH-2`; ties go to the lowest index. It is computed in STORE from the shadow registers. When `NUM_CH`=1, `dominant`=0.
- `enable` is sampled only in IDLE and at frame end. Dropping it mid-frame completes the current frame.
- Outputs hold their previous frame until the next publish. `rd_count` is never a partial frame.

## Timing
- Settle-plus-gate span per channel: `SETTLE_CYCLES` + 2^`AVG_LOG2`·`GATE_CYCLES` cycles; each STORE adds 1 cycle.
- Frame period: `NUM_CH`·(`SETTLE_CYCLES` + 2^`AVG_LOG2`·`GATE_CYCLES` + 1) cycles.
- `frame_valid` is asserted in the cycle after the last STORE. `rd_count`, `dominant` and `overflow` are updated on that same edge.
- `filter_sel` changes on the clock edge that enters SETTLE.
- An edge detected in the last GATE cycle belongs to that window. An edge detected in the first cycle of the next window belongs to the next window.
- Synchronizer latency: 3 cycles from a `signal` rise to the counter increment.
- `rst_n`=0 at any time, including mid-GATE: next edge goes to IDLE and all outputs, shadow registers and synchronizer flops reset to 0.

## Structure
- Package `color_freq_pkg` holds:
  - the FSM state enum;
  - the `CH_W` = max(1, $clog2(`NUM_CH`)) helper;
  - default parameter constants.
- Sub-module `pulse_edge_sync`: the 2-flop synchronizer plus rising-edge detector, with a one-cycle `edge` output.
- The FSM, counters, accumulator, shadow/output register banks and dominant compare live in the top module.

## Test plan
Unless a scenario says otherwise, use `NUM_CH`=4, `CNT_W`=20, `GATE_CYCLES`=1000, `SETTLE_CYCLES`=100, `AVG_LOG2`=1.

- **Basic count:** `signal` is a 100-cycle-period square wave on all channels and `enable`=1. Required: `frame_valid` pulse at cycle 4·(100+2000+1) after start, `rd_count`=10 for every channel, `overflow`=0.
- **Dominant select:** drive periods 200/50/100/20 cycles on `filter_sel` 0/1/2/3. Required: counts 5/20/10/50 and `dominant`=1, because clear channel 3 is excluded.
- **Saturation:** `CNT_W`=4 and a 4-cycle-period signal. Required: `rd_count`=15 on all channels and `overflow`=1.
- **Settle discard:** pulse `signal` only during SETTLE. Required: all counts 0.
- **Reset mid-GATE:** assert `rst_n`=0 mid-GATE of channel 2. Required: `busy`=0, `filter_sel`=0, `rd_count`=0 and no `frame_valid` pulse.
- **Enable drop:** deassert `enable` mid-channel 1. Required: the frame completes, one `frame_valid` pulse follows, then IDLE with `busy`=0.
